// File: rtl/wb_timer_sched.sv
// Round-robin delay scheduler: four clients share channel 0 of a Wishbone timer.
// Each granted request programs the timer, waits for its irq, then pulses done.
module wb_timer_sched #(
  parameter logic [31:0] TIMER_BASE = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   req_i,
  input  logic [127:0] delay_i,
  output logic [3:0]   done_o,
  output logic [1:0]   grant_o,
  output logic         busy_o,
  input  logic         timer_irq_i,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [31:0]  wbm_adr_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_dat_o,
  input  logic         wbm_ack_i
);

  localparam int unsigned NC = 4;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] OFS_TCR   = 32'h0000_0000;
  localparam logic [DW-1:0] OFS_CMP   = 32'h0000_0004;
  localparam logic [DW-1:0] OFS_CNT   = 32'h0000_0008;
  localparam logic [DW-1:0] TCR_START = 32'h0000_000A;

  typedef enum logic [3:0] {
    IDLE, ARB, WR_STOP, WR_CMP, WR_CNT, WR_START, WAIT_IRQ, WR_CLR, DONE
  } state_t;

  state_t          state_q, state_d, wr_next;
  logic [1:0]      grant_q, grant_d, last_q, last_d, pick, idx;
  logic [DW-1:0]   delay_q, delay_d, delay_sel, wr_adr, wr_dat;
  logic [DW-1:0]   adr_q, adr_d, dat_q, dat_d;
  logic            cancel_q, cancel_d, stb_q, stb_d, busy_q;
  logic [NC-1:0]   done_q, done_d;

  assign delay_sel = delay_i[DW*grant_q +: DW];

  // Register, address and data of the access each write state performs.
  always_comb begin
    wr_adr  = '0;
    wr_dat  = '0;
    wr_next = IDLE;
    case (state_q)
      WR_STOP:  begin wr_adr = TIMER_BASE + OFS_TCR; wr_dat = '0;        wr_next = WR_CMP;   end
      WR_CMP:   begin wr_adr = TIMER_BASE + OFS_CMP; wr_dat = delay_q;   wr_next = WR_CNT;   end
      WR_CNT:   begin wr_adr = TIMER_BASE + OFS_CNT; wr_dat = '0;        wr_next = WR_START; end
      WR_START: begin wr_adr = TIMER_BASE + OFS_TCR; wr_dat = TCR_START; wr_next = WAIT_IRQ; end
      WR_CLR:   begin wr_adr = TIMER_BASE + OFS_TCR; wr_dat = '0;        wr_next = DONE;     end
      default:  ;
    endcase
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    delay_d  = delay_q;
    cancel_d = cancel_q;
    stb_d    = 1'b0;
    adr_d    = '0;
    dat_d    = '0;
    done_d   = '0;

    // Lowest offset from last_served+1 wins; iterating downward lets it overwrite.
    pick = last_q;
    idx  = '0;
    for (int i = NC; i >= 1; i--) begin
      idx = last_q + 2'(i);
      if (req_i[idx]) pick = idx;
    end

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d  = ARB;
          grant_d  = pick;
          cancel_d = 1'b0;
        end
      end
      ARB: begin
        delay_d = delay_sel;
        if (delay_sel == '0) begin
          state_d         = DONE;
          done_d[grant_q] = 1'b1;
        end else begin
          state_d = WR_STOP;
        end
      end
      WR_STOP, WR_CMP, WR_CNT, WR_START, WR_CLR: begin
        // First cycle of each write state is the mandatory bus idle cycle.
        if (!stb_q) begin
          stb_d = 1'b1;
        end else if (wbm_ack_i) begin
          state_d = wr_next;
          if (state_q == WR_CLR && !cancel_q) done_d[grant_q] = 1'b1;
        end else begin
          stb_d = 1'b1;
        end
      end
      WAIT_IRQ: begin
        if (!req_i[grant_q]) begin
          cancel_d = 1'b1;
          state_d  = WR_CLR;
        end else if (timer_irq_i) begin
          state_d = WR_CLR;
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (stb_d) begin
      adr_d = wr_adr;
      dat_d = wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= 2'd3;
      delay_q  <= '0;
      cancel_q <= 1'b0;
      stb_q    <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      delay_q  <= delay_d;
      cancel_q <= cancel_d;
      stb_q    <= stb_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      done_q   <= done_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign wbm_cyc_o = stb_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = stb_q;
  assign wbm_sel_o = {4{stb_q}};
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign done_o    = done_q;
  assign grant_o   = grant_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_wb_timer_sched.sv
// Directed bench for wb_timer_sched with a Wishbone timer-channel model.
module tb_wb_timer_sched;

  localparam logic [31:0] BASE = 32'h4000_0100;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] delay = '0;
  logic [3:0]   done;
  logic [1:0]   grant;
  logic         busy;
  logic         irq = 1'b0;
  logic         cyc, stb, we;
  logic [31:0]  adr, dat;
  logic [3:0]   sel;
  logic         ack = 1'b0;

  always #5 clk = ~clk;

  wb_timer_sched #(.TIMER_BASE(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .req_i(req), .delay_i(delay),
    .done_o(done), .grant_o(grant), .busy_o(busy), .timer_irq_i(irq),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_sel_o(sel), .wbm_dat_o(dat), .wbm_ack_i(ack)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave / timer model state and bus log
  int          ack_delay = 0;
  bit          spur_ack  = 1'b0;
  bit          real_ack  = 1'b0;
  int          wcnt = 0;
  logic [31:0] tcr = '0, cmp = '0, cnt = '0;
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  int          stb_cycles = 0;
  int          done_cnt = 0;
  logic        prev_stb = 1'b0;
  logic [31:0] prev_adr = '0, prev_dat = '0;
  logic        rst_q = 1'b0;

  always @(posedge clk) rst_q <= reset_n;

  // Bus protocol monitor, then slave response and timer update, all on negedge.
  always @(negedge clk) begin
    if (rst_q && prev_stb && ack) begin
      check("idle_after_ack", 32'(stb), 32'd0);
    end
    if (rst_q && prev_stb && !ack) begin
      check("stb_hold", 32'(stb), 32'd1);
      check("adr_hold", adr, prev_adr);
      check("dat_hold", dat, prev_dat);
    end
    if (stb) begin
      stb_cycles++;
      check("we_cyc_sel", 32'({we, cyc, sel}), 32'h3F);
    end
    if (done !== 4'b0) begin
      done_cnt++;
      check("done_onehot", 32'(done), 32'(4'b0001 << grant));
    end
    prev_stb = stb;
    prev_adr = adr;
    prev_dat = dat;

    if (stb && !real_ack) begin
      if (wcnt >= ack_delay) begin
        ack = 1'b1;
        real_ack = 1'b1;
        wcnt = 0;
        log_adr.push_back(adr);
        log_dat.push_back(dat);
        case (adr - BASE)
          32'h0:   tcr = dat;
          32'h4:   cmp = dat;
          32'h8:   cnt = dat;
          default: ;
        endcase
      end else begin
        wcnt++;
        ack = 1'b0;
      end
    end else begin
      real_ack = 1'b0;
      wcnt = 0;
      ack = !stb && spur_ack;
    end

    if (tcr[1] && cnt != cmp) cnt = cnt + 32'd1;
    irq = tcr[1] && tcr[3] && (cnt == cmp);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output logic [3:0] seen);
    seen = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done !== 4'b0) begin
        seen = done;
        return;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
  endtask

  task automatic check_log(input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < log_adr.size()) begin
      check("log_adr", log_adr[idx], a);
      check("log_dat", log_dat[idx], d);
    end else begin
      check("log_len", 32'(log_adr.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_seq(input int b, input logic [31:0] cmp_val);
    check_log(b + 0, BASE + 32'h0, 32'h0);
    check_log(b + 1, BASE + 32'h4, cmp_val);
    check_log(b + 2, BASE + 32'h8, 32'h0);
    check_log(b + 3, BASE + 32'h0, 32'hA);
    check_log(b + 4, BASE + 32'h0, 32'h0);
  endtask

  task automatic check_reset_outputs();
    check("rst_done", 32'(done), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cyc", 32'(cyc), 32'h0);
    check("rst_stb", 32'(stb), 32'h0);
    check("rst_we", 32'(we), 32'h0);
    check("rst_adr", adr, 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_dat", dat, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] seen;
    int b, sc, dc;

    // Reset state
    step(3);
    check_reset_outputs();
    reset_n = 1'b1;
    step(1);

    // Single request, delay 10, with latency check
    b = log_adr.size(); sc = stb_cycles;
    delay[31:0] = 32'd10;
    req = 4'b0001;
    step(1);
    check("lat_arb_busy", 32'(busy), 32'd1);
    check("lat_arb_grant", 32'(grant), 32'd0);
    check("lat_arb_stb", 32'(stb), 32'd0);
    step(1);
    check("lat_stop_stb0", 32'(stb), 32'd0);
    step(1);
    check("lat_stop_stb1", 32'(stb), 32'd1);
    check("lat_stop_adr", adr, BASE);
    wait_done(300, seen);
    check("single_done", 32'(seen), 32'h1);
    req = 4'b0000;
    step(1);
    check("single_done_clr", 32'(done), 32'h0);
    check("single_busy_low", 32'(busy), 32'd0);
    check_seq(b, 32'd10);
    check("single_stb_cycles", 32'(stb_cycles - sc), 32'd5);

    // Zero delay: IDLE, ARB, DONE with no bus traffic
    b = log_adr.size(); sc = stb_cycles;
    delay[95:64] = 32'd0;
    req = 4'b0100;
    step(1);
    check("zero_arb_grant", 32'(grant), 32'd2);
    check("zero_arb_done", 32'(done), 32'h0);
    step(1);
    check("zero_done", 32'(done), 32'h4);
    req = 4'b0000;
    step(1);
    check("zero_busy_low", 32'(busy), 32'd0);
    check("zero_no_stb", 32'(stb_cycles - sc), 32'd0);
    check("zero_no_writes", 32'(log_adr.size() - b), 32'd0);

    // Round robin from reset: 0,1,2,3,0
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    delay = {4{32'd3}};
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_done(200, seen);
      check("rr_done", 32'(seen), 32'(4'b0001 << (j % 4)));
      if (j == 4) req = 4'b0000;
    end
    step(2);
    check("rr_busy_low", 32'(busy), 32'd0);

    // Cancel client 1 while waiting on irq
    b = log_adr.size(); dc = done_cnt;
    delay[63:32] = 32'd1000;
    req = 4'b0010;
    for (int i = 0; i < 200 && log_adr.size() < b + 4; i++) step(1);
    step(3);
    check("cancel_grant", 32'(grant), 32'd1);
    check("cancel_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    wait_idle(100);
    check("cancel_idle", 32'(busy), 32'd0);
    check("cancel_writes", 32'(log_adr.size() - b), 32'd5);
    check_log(b + 4, BASE, 32'h0);
    check("cancel_no_done", 32'(done_cnt - dc), 32'd0);

    // Ack stall of 5 cycles, stray acks while stb low, other client toggling
    b = log_adr.size(); sc = stb_cycles;
    ack_delay = 5;
    spur_ack = 1'b1;
    delay[31:0] = 32'd4;
    req = 4'b0001;
    step(6);
    req = 4'b0101;
    step(10);
    check("stall_grant_kept", 32'(grant), 32'd0);
    req = 4'b0001;
    wait_done(400, seen);
    check("stall_done", 32'(seen), 32'h1);
    req = 4'b0000;
    spur_ack = 1'b0;
    step(2);
    check("stall_busy_low", 32'(busy), 32'd0);
    check_seq(b, 32'd4);
    check("stall_stb_cycles", 32'(stb_cycles - sc), 32'd30);

    // Reset while COMPARE0 write is stalled with stb high
    delay[31:0] = 32'd10;
    req = 4'b0001;
    for (int i = 0; i < 100 && !(stb === 1'b1 && adr === BASE + 32'h4); i++) step(1);
    check("rstmid_in_cmp", adr, BASE + 32'h4);
    reset_n = 1'b0;
    req = 4'b0000;
    step(1);
    check_reset_outputs();
    step(1);
    reset_n = 1'b1;
    ack_delay = 0;
    req = 4'b0001;
    step(1);
    check("rstmid_arb_busy", 32'(busy), 32'd1);
    check("rstmid_arb_grant", 32'(grant), 32'd0);
    wait_done(300, seen);
    check("rstmid_done", 32'(seen), 32'h1);
    req = 4'b0000;
    step(2);
    check("rstmid_busy_low", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/wb_timer_sched.md
WB_TIMER_SCHED -- requirements
Module: wb_timer_sched

Interface
REQ-001 Parameter SHALL be: TIMER_BASE, 32'h0000_0000, byte base address of the timer whose channel 0 this block owns (TCR0 +0x00, COMPARE0 +0x04, COUNTER0 +0x08).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 req_i  input  4  per-client delay request, level; held high until done_o bit pulses or the client cancels.
REQ-005 delay_i  input  128  client i delay in clk cycles at bits [32i+31:32i].
REQ-006 done_o  output  4  one-cycle pulse to the granted client when its delay has expired.
REQ-007 grant_o  output  2  index of the client currently being served; valid while busy_o=1.
REQ-008 busy_o  output  1  high in every state except IDLE.
REQ-009 timer_irq_i  input  1  timer channel 0 trigger line.
REQ-010 Wishbone master outputs SHALL be: wbm_cyc_o 1, wbm_stb_o 1, wbm_we_o 1, wbm_adr_o 32, wbm_sel_o 4, wbm_dat_o 32; wbm_ack_i SHALL be a 1-bit input.

Function
REQ-011 FSM states SHALL be IDLE, ARB, WR_STOP, WR_CMP, WR_CNT, WR_START, WAIT_IRQ, WR_CLR, DONE.
REQ-012 IDLE->ARB when any req_i bit is high; otherwise stay in IDLE.
REQ-013 ARB: grant the first requesting index found by searching upward, with wrap, from (last_served+1) mod 4; latch delay_i of that client; last_served resets to 3 so index 0 wins first.
REQ-014 ARB: a latched delay of 0 SHALL go directly to DONE with no bus traffic; otherwise go to WR_STOP.
REQ-015 Bus writes: WR_STOP TCR0<=0; WR_CMP COMPARE0<=delay; WR_CNT COUNTER0<=0; WR_START TCR0<=32'h0000_000A (EN|IRQEN, AR=0); WR_CLR TCR0<=0. Each address = TIMER_BASE + offset.
REQ-016 Each write state SHALL assert cyc, stb and we with sel=4'hF on its first cycle, and hold them with constant adr/dat until wbm_ack_i is sampled high.
REQ-017 On the cycle after ack, cyc/stb SHALL be low for at least one cycle before the next access begins (one idle cycle between accesses).
REQ-018 An ack sampled while stb is low SHALL be ignored.
REQ-019 WR_START is followed by WAIT_IRQ; WAIT_IRQ->WR_CLR on timer_irq_i=1.
REQ-020 Cancellation: if req_i[grant] falls while in WAIT_IRQ, go to WR_CLR. The later DONE SHALL suppress done_o.
REQ-021 In DONE (one cycle), pulse done_o[grant] unless cancelled, set last_served=grant, and go to IDLE.
REQ-022 req_i changes by non-granted clients SHALL NOT disturb a transaction in progress.
REQ-023 req_i[grant] falling outside WAIT_IRQ SHALL be honoured only at WAIT_IRQ.
REQ-024 Latency: req_i high in IDLE at edge k -> ARB at k+1 -> first stb high after edge k+2.
REQ-025 At most one done_o bit SHALL be high at any cycle.
REQ-026 done_o SHALL NOT pulse for a client whose request was never granted.
REQ-027 No transaction timeout SHALL exist; the block waits indefinitely on ack or irq.

Reset
REQ-028 reset_n=0 at an edge SHALL force state IDLE, last_served=3 and cancel flag=0.
REQ-029 During reset all outputs SHALL be 0: cyc, stb, we, adr, sel, dat, done_o, grant_o, busy_o.
REQ-030 Reset mid-bus-cycle SHALL drop stb/cyc at the same edge.
REQ-031 Timer state SHALL NOT be rewritten by reset; the next transaction's WR_STOP cleans it.

Verification
REQ-032 Single request, req_i=4'b0001, delay0=10, timer model attached -> bus sequence: TCR0=0, COMPARE0=10, COUNTER0=0, TCR0=0xA, then TCR0=0 after irq; done_o=4'b0001 for 1 cycle; busy_o low after.
REQ-033 Round-robin, req_i=4'b1111 held with all delays=3 -> grants in order 0,1,2,3,0; done_o pulses appear in that order.
REQ-034 Zero delay, req_i=4'b0100, delay2=0 -> no stb asserted; done_o=4'b0100 three cycles after the request (IDLE, ARB, DONE).
REQ-035 Cancel, client 1 with delay=1000, req_i[1] dropped at WAIT_IRQ -> WR_CLR write issued; no done_o pulse; return to IDLE.
REQ-036 Ack stall, wbm_ack_i delayed 5 cycles on each write -> adr/dat held stable throughout; one idle cycle between accesses.
REQ-037 Reset during WR_CMP with stb high -> all outputs 0 next cycle; a new req_i=4'b0001 is then served with grant_o=0.
